seq_bcd_converter: RTL and testbench

- Sequential double-dabble converter placed directly downstream of the shift-add multiplier's product register.
- Takes the 16-bit product, signed or unsigned, and produces a sign flag plus packed BCD digits for the 7-segment display / scroll logic.
- Processes one bit per clock; start/done handshake.
- Runs on the divided system clock, same as the multiplier datapath.

---
 rtl/seq_bcd_converter.sv | 156 +++++++++++++++
 tb/tb_seq_bcd_converter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_bcd_converter.sv
// Sequential double-dabble converter: signed/unsigned binary product to sign + packed BCD.
// One shift per clock; the result registers update only when a conversion completes.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | waiting for start; magnitude and pending sign captured on start
// ST_LOAD | clear BCD scratch, load magnitude into shift register
// ST_SHIFT| add-3 adjust then shift, WIDTH iterations
// ST_DONE | one-cycle done pulse; bcd/sign/valid already registered
module seq_bcd_converter #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  start,
   input  logic                  signed_mode,
   input  logic [WIDTH-1:0]      binary,
   output logic                  busy,
   output logic                  done,
   output logic                  valid,
   output logic                  sign,
   output logic [4*DIGITS-1:0]   bcd
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT,
      ST_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] mag_q, mag_d;
   logic             pend_sign_q, pend_sign_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [BW-1:0]    scratch_q, scratch_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [BW-1:0]    bcd_q, bcd_d;
   logic             sign_q, sign_d;
   logic             valid_q, valid_d;

   logic [BW-1:0]    adj;
   logic [BW-1:0]    scratch_nxt;
   logic [WIDTH-1:0] mag_in;
   logic             neg_in;

   // Add-3 correction so each digit carries correctly on the following shift.
   always_comb begin
      adj = scratch_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (scratch_q[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
         end
      end
   end

   assign scratch_nxt = {adj[BW-2:0], shift_q[WIDTH-1]};

   // Most-negative input negates to itself, which is the correct unsigned magnitude.
   assign neg_in = signed_mode & binary[WIDTH-1];
   assign mag_in = neg_in ? (~binary + WIDTH'(1)) : binary;

   always_comb begin
      state_d     = state_q;
      mag_d       = mag_q;
      pend_sign_d = pend_sign_q;
      shift_d     = shift_q;
      scratch_d   = scratch_q;
      cnt_d       = cnt_q;
      bcd_d       = bcd_q;
      sign_d      = sign_q;
      valid_d     = valid_q;

      if (clr) begin
         state_d     = ST_IDLE;
         mag_d       = '0;
         pend_sign_d = 1'b0;
         shift_d     = '0;
         scratch_d   = '0;
         cnt_d       = '0;
         bcd_d       = '0;
         sign_d      = 1'b0;
         valid_d     = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  mag_d       = mag_in;
                  pend_sign_d = neg_in;
                  state_d     = ST_LOAD;
               end
            end
            ST_LOAD: begin
               scratch_d = '0;
               shift_d   = mag_q;
               cnt_d     = '0;
               state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
               scratch_d = scratch_nxt;
               shift_d   = {shift_q[WIDTH-2:0], 1'b0};
               cnt_d     = cnt_q + CW'(1);
               if (cnt_q == LAST_CNT) begin
                  bcd_d   = scratch_nxt;
                  sign_d  = pend_sign_q;
                  valid_d = 1'b1;
                  state_d = ST_DONE;
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         mag_q       <= '0;
         pend_sign_q <= 1'b0;
         shift_q     <= '0;
         scratch_q   <= '0;
         cnt_q       <= '0;
         bcd_q       <= '0;
         sign_q      <= 1'b0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         mag_q       <= mag_d;
         pend_sign_q <= pend_sign_d;
         shift_q     <= shift_d;
         scratch_q   <= scratch_d;
         cnt_q       <= cnt_d;
         bcd_q       <= bcd_d;
         sign_q      <= sign_d;
         valid_q     <= valid_d;
      end
   end

   assign busy  = (state_q != ST_IDLE);
   assign done  = (state_q == ST_DONE);
   assign valid = valid_q;
   assign sign  = sign_q;
   assign bcd   = bcd_q;

endmodule

// File: tb/tb_seq_bcd_converter.sv
// Bench for seq_bcd_converter: vector table plus scoreboard-checked results and
// hand-written sequences for busy, clear and reset corner cases.
module tb_seq_bcd_converter;

   localparam int WIDTH  = 16;
   localparam int DIGITS = 5;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        clr = 1'b0;
   logic        start = 1'b0;
   logic        signed_mode = 1'b0;
   logic [15:0] binary = '0;
   logic        busy, done, valid, sign;
   logic [19:0] bcd;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        sm;
      logic [15:0] bin;
      logic [19:0] exp_bcd;
      logic        exp_sign;
   } vec_t;

   typedef struct {
      logic [19:0] b;
      logic        s;
   } exp_t;

   exp_t        sb_q[$];
   logic [19:0] last_bcd = '0;
   vec_t        vecs[11];

   seq_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
      .clk(clk), .rst(rst), .clr(clr), .start(start), .signed_mode(signed_mode),
      .binary(binary), .busy(busy), .done(done), .valid(valid), .sign(sign), .bcd(bcd)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time exhausted, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference by repeated division, independent of the shift-and-add algorithm.
   function automatic logic [20:0] model(input logic sm, input logic [15:0] b);
      int          m;
      logic [19:0] r;
      logic        neg;
      neg = sm & b[15];
      m   = neg ? (65536 - int'(b)) : int'(b);
      for (int i = 0; i < 5; i++) begin
         r[4*i +: 4] = 4'(m % 10);
         m = m / 10;
      end
      return {neg, r};
   endfunction

   // Scoreboard: every done pops one expected result.
   always @(posedge clk) begin
      #1;
      if (done === 1'b1) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 with bcd=0x%0h, expected no done", bcd);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("sb_bcd", 32'(bcd), 32'(e.b));
            chk("sb_sign", 32'(sign), 32'(e.s));
            chk("sb_valid", 32'(valid), 32'd1);
            last_bcd = e.b;
         end
      end
   end

   task automatic run_conv(input logic sm, input logic [15:0] b, input logic [19:0] eb, input logic es);
      int   n;
      logic stable;
      n      = 0;
      stable = 1'b1;
      @(negedge clk);
      signed_mode = sm;
      binary      = b;
      start       = 1'b1;
      sb_q.push_back('{eb, es});
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
      while (n < 40) begin
         @(posedge clk);
         #1;
         n++;
         if (done === 1'b1) break;
         if (bcd !== last_bcd) stable = 1'b0;
      end
      chk("latency", 32'(n), 32'd17);
      chk("prev_result_stable", 32'(stable), 32'd1);
      @(posedge clk);
      #1;
      chk("done_width", 32'(done), 32'd0);
      chk("busy_idle", 32'(busy), 32'd0);
      chk("held_bcd", 32'(bcd), 32'(eb));
      chk("held_sign", 32'(sign), 32'(es));
   endtask

   initial begin
      int          ndone;
      int          first;
      int          dk[$];
      logic        quiet;
      logic [20:0] m;
      logic [15:0] rb;
      logic        rs;

      vecs[0]  = '{1'b0, 16'hFFFF, 20'h65535, 1'b0};
      vecs[1]  = '{1'b1, 16'hFF9C, 20'h00100, 1'b1};
      vecs[2]  = '{1'b1, 16'h8000, 20'h32768, 1'b1};
      vecs[3]  = '{1'b1, 16'h7FFF, 20'h32767, 1'b0};
      vecs[4]  = '{1'b1, 16'hF7E0, 20'h02080, 1'b1};
      vecs[5]  = '{1'b0, 16'hF7E0, 20'h63456, 1'b0};
      vecs[6]  = '{1'b1, 16'h0000, 20'h00000, 1'b0};
      vecs[7]  = '{1'b0, 16'h0000, 20'h00000, 1'b0};
      vecs[8]  = '{1'b1, 16'hFFFF, 20'h00001, 1'b1};
      vecs[9]  = '{1'b0, 16'h270F, 20'h09999, 1'b0};
      vecs[10] = '{1'b0, 16'h8000, 20'h32768, 1'b0};

      // Reset then idle
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_bcd", 32'(bcd), 32'd0);
      chk("rst_sign", 32'(sign), 32'd0);
      quiet = 1'b1;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (busy !== 1'b0 || done !== 1'b0) quiet = 1'b0;
      end
      chk("idle_no_activity", 32'(quiet), 32'd1);

      foreach (vecs[i]) run_conv(vecs[i].sm, vecs[i].bin, vecs[i].exp_bcd, vecs[i].exp_sign);

      for (int i = 0; i < 4; i++) begin
         rb = 16'($urandom);
         rs = 1'($urandom_range(0, 1));
         m  = model(rs, rb);
         run_conv(rs, rb, m[19:0], m[20]);
      end

      // start pulses while busy and input changes after the sample are ignored
      @(negedge clk);
      signed_mode = 1'b0;
      binary      = 16'h1234;
      start       = 1'b1;
      sb_q.push_back('{20'h04660, 1'b0});
      @(posedge clk);
      ndone = 0;
      first = 0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         start = (k == 5 || k == 10);
         if (k == 3) begin
            binary      = 16'hFFFF;
            signed_mode = 1'b1;
         end
         @(posedge clk);
         #1;
         if (done === 1'b1) begin
            ndone++;
            if (first == 0) first = k;
         end
      end
      start = 1'b0;
      chk("busy_start_ignored_ndone", 32'(ndone), 32'd1);
      chk("busy_start_latency", 32'(first), 32'd17);

      // start held high: back-to-back conversions
      @(negedge clk);
      signed_mode = 1'b0;
      binary      = 16'd99;
      start       = 1'b1;
      repeat (3) sb_q.push_back('{20'h00099, 1'b0});
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) dk.push_back(k);
      end
      chk("held_start_ndone", 32'(dk.size()), 32'd3);
      if (dk.size() >= 3) begin
         chk("held_start_gap1", 32'(dk[1] - dk[0]), 32'd19);
         chk("held_start_gap2", 32'(dk[2] - dk[1]), 32'd19);
      end
      @(negedge clk);
      start = 1'b0;
      clr   = 1'b1;
      @(posedge clk);
      #1;
      chk("clr_after_held_busy", 32'(busy), 32'd0);
      chk("clr_after_held_bcd", 32'(bcd), 32'd0);
      @(negedge clk);
      clr      = 1'b0;
      last_bcd = '0;

      // Abort at SHIFT cycle 8
      run_conv(1'b0, 16'd12345, 20'h12345, 1'b0);
      @(negedge clk);
      binary = 16'hABCD;
      start  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      chk("abort_prev_held", 32'(bcd), 32'h12345);
      chk("abort_busy_pre", 32'(busy), 32'd1);
      @(negedge clk);
      clr = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_valid", 32'(valid), 32'd0);
      chk("abort_bcd", 32'(bcd), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      @(negedge clk);
      clr      = 1'b0;
      last_bcd = '0;
      quiet    = 1'b1;
      repeat (25) begin
         @(posedge clk);
         #1;
         if (busy !== 1'b0 || done !== 1'b0) quiet = 1'b0;
      end
      chk("abort_no_done", 32'(quiet), 32'd1);

      // clr and start together
      @(negedge clk);
      clr    = 1'b1;
      start  = 1'b1;
      binary = 16'd5;
      @(posedge clk);
      #1;
      chk("clr_start_busy", 32'(busy), 32'd0);
      @(negedge clk);
      clr   = 1'b0;
      start = 1'b0;
      @(posedge clk);
      #1;
      chk("clr_start_busy_after", 32'(busy), 32'd0);

      // Async reset mid-SHIFT
      run_conv(1'b1, 16'hFFFE, 20'h00002, 1'b1);
      @(negedge clk);
      binary = 16'h4321;
      start  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_valid", 32'(valid), 32'd0);
      chk("arst_bcd", 32'(bcd), 32'd0);
      chk("arst_sign", 32'(sign), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst      = 1'b1;
      last_bcd = '0;
      run_conv(1'b0, 16'd40000, 20'h40000, 1'b0);

      repeat (3) @(posedge clk);
      chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
